// File: rtl/mfm_dpll_sync_if.sv
// Read-channel bundle between the drive/controller side and the MFM data separator.
// Latency: none (wires only).
// Backpressure: none; the recovered stream is free-running and cannot be stalled.
// Signals: iRDATA_N raw active-low read pulses, iSTART read enable,
//          oRCLK recovered cell clock, o3WORDS 48-cell window (bit 0 newest),
//          oSYNC sync-mark strobe, oLOCK DPLL lock indicator.
interface mfm_dpll_sync_if;
  logic        iRDATA_N;
  logic        iSTART;
  logic        oRCLK;
  logic [47:0] o3WORDS;
  logic        oSYNC;
  logic        oLOCK;

  // master: the data separator, which sources the recovered stream
  modport master (
    input  iRDATA_N, iSTART,
    output oRCLK, o3WORDS, oSYNC, oLOCK
  );

  // slave: drive front end and MFM byte decoder side
  modport slave (
    output iRDATA_N, iSTART,
    input  oRCLK, o3WORDS, oSYNC, oLOCK
  );
endinterface

// File: rtl/mfm_dpll_sync.sv
// MFM data separator: digital PLL recovers the cell clock, shifts cells into a 48-bit window, flags triple-A1 sync.
// Latency: read pulse -> rHIT 3 iCLK; window/oRCLK update on the window-close edge; oSYNC valid the cycle after it.
// Backpressure: none; the DPLL free-runs and iSTART low only clears window and sync state.
// Ports: iCLK system clock, iRESET_N async active-low reset,
//        bus (master modport): iRDATA_N, iSTART in; oRCLK, o3WORDS, oSYNC, oLOCK out.
module mfm_dpll_sync #(
  parameter int          HALF_CELL = 32,
  parameter logic [47:0] SYNC_PAT  = 48'h448944894489
) (
  input  logic            iCLK,
  input  logic            iRESET_N,
  mfm_dpll_sync_if.master bus
);
  localparam int PW = $clog2(HALF_CELL);
  localparam logic [PW-1:0] LAST    = PW'(HALF_CELL - 1);
  localparam logic [PW-1:0] MID     = PW'(HALF_CELL / 2);
  localparam logic [PW-1:0] RET_LT  = PW'(HALF_CELL / 2 - 1);
  localparam logic [PW-1:0] ADV_LT  = PW'(HALF_CELL - 2);
  localparam logic [PW-1:0] BAND_LO = PW'(HALF_CELL / 2 - HALF_CELL / 8);
  localparam logic [PW-1:0] BAND_HI = PW'(HALF_CELL / 2 + HALF_CELL / 8);

  logic          rSync1, rSync2, rSync3;
  logic          pulse;
  logic          wc;
  logic [PW-1:0] rPH, phNext;
  logic          rSeen;   // a pulse has already been taken in this window
  logic          rHIT;
  logic          rRCLK;
  logic          rSYNC;
  logic [47:0]   rWin, winShift;
  logic [3:0]    rLK;

  // Synchronizer idles high so releasing reset never fakes a falling edge.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      rSync1 <= 1'b1;
      rSync2 <= 1'b1;
      rSync3 <= 1'b1;
    end else begin
      rSync1 <= bus.iRDATA_N;
      rSync2 <= rSync1;
      rSync3 <= rSync2;
    end
  end

  assign pulse    = rSync3 & ~rSync2;
  assign wc       = (rPH == LAST);
  assign winShift = {rWin[46:0], rHIT};

  // Phase steering: an early pulse holds the counter one cycle, a late one
  // skips a count. The upper bound on advance keeps the counter from jumping
  // over the window-close value. Only the first pulse of a window steers.
  always_comb begin
    phNext = rPH + 1'b1;
    if (wc) begin
      phNext = '0;
    end else if (pulse && !rSeen) begin
      if (rPH < RET_LT) begin
        phNext = rPH;
      end else if (rPH > MID && rPH < ADV_LT) begin
        phNext = rPH + PW'(2);
      end
    end
  end

  // DPLL and lock counter keep running regardless of iSTART.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      rPH   <= '0;
      rRCLK <= 1'b0;
      rSeen <= 1'b0;
      rLK   <= 4'd0;
    end else begin
      rPH <= phNext;
      if (wc) begin
        rRCLK <= ~rRCLK;
        rSeen <= 1'b0;
      end else if (pulse) begin
        rSeen <= 1'b1;
      end
      if (pulse && !rSeen) begin
        if (rPH >= BAND_LO && rPH <= BAND_HI) begin
          if (rLK != 4'hF) rLK <= rLK + 4'd1;
        end else begin
          if (rLK != 4'h0) rLK <= rLK - 4'd1;
        end
      end
    end
  end

  // Cell window and sync compare. A pulse landing on the close edge belongs
  // to the window that is just starting.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      rWin  <= '0;
      rHIT  <= 1'b0;
      rSYNC <= 1'b0;
    end else if (!bus.iSTART) begin
      rWin  <= '0;
      rHIT  <= 1'b0;
      rSYNC <= 1'b0;
    end else begin
      rSYNC <= wc && (winShift == SYNC_PAT);
      if (wc) begin
        rWin <= winShift;
        rHIT <= pulse;
      end else if (pulse) begin
        rHIT <= 1'b1;
      end
    end
  end

  assign bus.oRCLK   = rRCLK;
  assign bus.o3WORDS = rWin;
  assign bus.oSYNC   = rSYNC;
  assign bus.oLOCK   = rLK[3];
endmodule

// File: tb/tb_mfm_dpll_sync.sv
// Directed bench for mfm_dpll_sync: reset state, cell timing, phase steering, lock, sync detection, iSTART gating.
// Stimulus is aligned to the recovered oRCLK; pulses are placed at a chosen phase inside each window.
// All outputs are sampled on the falling clock edge.
module tb_mfm_dpll_sync;
  logic iCLK = 1'b0;
  logic iRESET_N;

  mfm_dpll_sync_if bus();

  mfm_dpll_sync #(
    .HALF_CELL(32),
    .SYNC_PAT (48'h448944894489)
  ) dut (
    .iCLK    (iCLK),
    .iRESET_N(iRESET_N),
    .bus     (bus)
  );

  always #5 iCLK = ~iCLK;

  int          total = 0;
  int          bad   = 0;
  int          syncCnt;
  int          syncAt;
  int          winIdx;
  logic [47:0] syncWin;
  logic        cellQ[$];
  logic        prevBit;

  // Runs one recovered window starting at the negedge where oRCLK last
  // toggled. A pulse for phase c is driven low c-2 negedges in, so the edge
  // event is seen while the phase counter reads c. Returns the window length.
  task automatic run_window(input int c1, input int c2, output int len);
    logic last;
    bit   done;
    last = bus.oRCLK;
    len  = 0;
    done = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge iCLK);
      len = n;
      if (bus.oSYNC === 1'b1) begin
        syncCnt++;
        syncAt  = winIdx;
        syncWin = bus.o3WORDS;
      end
      if (bus.oRCLK !== last) done = 1;
      else if (n == c1 - 2 || n == c2 - 2) bus.iRDATA_N = 1'b0;
      else if (n == c1 || n == c2) bus.iRDATA_N = 1'b1;
    end
    winIdx++;
    if (!done) begin
      total++; bad++;
      $display("FAIL window_timeout: no oRCLK toggle within 40 cycles, want <= 33");
    end
  endtask

  task automatic do_reset(input logic start);
    int len;
    bus.iSTART   = start;
    bus.iRDATA_N = 1'b1;
    iRESET_N     = 1'b0;
    repeat (3) @(negedge iCLK);
    iRESET_N = 1'b1;
    run_window(-1, -1, len);
    winIdx  = 0;
    syncCnt = 0;
    syncAt  = -1;
    syncWin = '0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      cellQ.push_back(~(prevBit | b[i]));
      cellQ.push_back(b[i]);
      prevBit = b[i];
    end
  endtask

  task automatic push_a1();
    logic [15:0] w;
    w = 16'h4489;
    for (int i = 15; i >= 0; i--) cellQ.push_back(w[i]);
    prevBit = 1'b1;
  endtask

  // 12x4E, 12x00, 3xA1 with missing clock: 432 cells.
  task automatic build_stream();
    cellQ.delete();
    prevBit = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'h4E);
    for (int i = 0; i < 12; i++) push_byte(8'h00);
    for (int i = 0; i < 3; i++) push_a1();
  endtask

  task automatic run_stream(input int startAt, input int stopAt);
    int len;
    for (int i = 0; i < stopAt; i++) begin
      if (i == startAt) bus.iSTART = 1'b1;
      run_window(cellQ[i] ? 16 : -1, -1, len);
    end
  endtask

  task automatic test_reset();
    int len;
    bus.iSTART   = 1'b1;
    bus.iRDATA_N = 1'b1;
    iRESET_N     = 1'b0;
    @(negedge iCLK);
    total++; if (bus.oRCLK !== 1'b0) begin bad++; $display("FAIL rst_rclk: got %b want 0", bus.oRCLK); end
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL rst_words: got %h want 0", bus.o3WORDS); end
    total++; if (bus.oSYNC !== 1'b0) begin bad++; $display("FAIL rst_sync: got %b want 0", bus.oSYNC); end
    total++; if (bus.oLOCK !== 1'b0) begin bad++; $display("FAIL rst_lock: got %b want 0", bus.oLOCK); end
    repeat (2) @(negedge iCLK);
    iRESET_N = 1'b1;
    syncCnt = 0;
    run_window(-1, -1, len);
    total++; if (len !== 32) begin bad++; $display("FAIL idle_first_len: got %0d want 32", len); end
    total++; if (bus.oRCLK !== 1'b1) begin bad++; $display("FAIL idle_rclk_hi: got %b want 1", bus.oRCLK); end
    run_window(-1, -1, len);
    total++; if (len !== 32) begin bad++; $display("FAIL idle_second_len: got %0d want 32", len); end
    total++; if (bus.oRCLK !== 1'b0) begin bad++; $display("FAIL idle_rclk_lo: got %b want 0", bus.oRCLK); end
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL idle_words: got %h want 0", bus.o3WORDS); end
    total++; if (bus.oLOCK !== 1'b0) begin bad++; $display("FAIL idle_lock: got %b want 0", bus.oLOCK); end
  endtask

  // Centred pulses in every other window: no steering, lock after 8 pulses.
  task automatic test_alternate();
    int len;
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      run_window(16, -1, len);
      total++; if (len !== 32) begin bad++; $display("FAIL alt_len_hit%0d: got %0d want 32", k, len); end
      run_window(-1, -1, len);
      total++; if (len !== 32) begin bad++; $display("FAIL alt_len_gap%0d: got %0d want 32", k, len); end
      if (k == 6) begin
        total++; if (bus.oLOCK !== 1'b0) begin bad++; $display("FAIL alt_lock_7: got %b want 0", bus.oLOCK); end
      end
      if (k == 7) begin
        total++; if (bus.oLOCK !== 1'b1) begin bad++; $display("FAIL alt_lock_8: got %b want 1", bus.oLOCK); end
      end
    end
    total++; if (bus.o3WORDS !== 48'h0000000AAAAA) begin bad++; $display("FAIL alt_words: got %h want 0000000aaaaa", bus.o3WORDS); end
  endtask

  // Phase steering table: {first pulse phase, second pulse phase, window length}.
  task automatic test_correction();
    int len;
    int tab [12][3] = '{
      '{17, -1, 31}, '{18, -1, 31}, '{19, -1, 31}, '{20, -1, 31},
      '{29, -1, 31}, '{30, -1, 32}, '{15, -1, 32}, '{16, -1, 32},
      '{14, -1, 33}, '{10, -1, 33}, '{10, 20, 33}, '{20, 26, 31}
    };
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      run_window(tab[k][0], tab[k][1], len);
      total++;
      if (len !== tab[k][2]) begin
        bad++;
        $display("FAIL corr_len_c%0d_%0d: got %0d want %0d", tab[k][0], tab[k][1], len, tab[k][2]);
      end
    end
    total++; if (bus.o3WORDS !== 48'h000000000FFF) begin bad++; $display("FAIL corr_words: got %h want 000000000fff", bus.o3WORDS); end
  endtask

  task automatic test_back_to_back();
    int len;
    do_reset(1'b1);
    for (int k = 0; k < 48; k++) run_window(16, -1, len);
    total++; if (bus.o3WORDS !== 48'hFFFFFFFFFFFF) begin bad++; $display("FAIL b2b_words: got %h want ffffffffffff", bus.o3WORDS); end
    total++; if (bus.oLOCK !== 1'b1) begin bad++; $display("FAIL b2b_lock: got %b want 1", bus.oLOCK); end
    total++; if (syncCnt !== 0) begin bad++; $display("FAIL b2b_nosync: got %0d strobes want 0", syncCnt); end
  endtask

  task automatic test_sync();
    int len;
    do_reset(1'b1);
    run_stream(0, cellQ.size());
    total++; if (syncCnt !== 1) begin bad++; $display("FAIL sync_count: got %0d want 1", syncCnt); end
    total++; if (syncAt !== 431) begin bad++; $display("FAIL sync_window: got %0d want 431", syncAt); end
    total++; if (syncWin !== 48'h448944894489) begin bad++; $display("FAIL sync_words: got %h want 448944894489", syncWin); end
    run_window(-1, -1, len);
    total++; if (syncCnt !== 1) begin bad++; $display("FAIL sync_once: got %0d want 1", syncCnt); end
    bus.iSTART = 1'b0;
    @(negedge iCLK);
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL start_fall_clear: got %h want 0", bus.o3WORDS); end
  endtask

  task automatic test_start_gate();
    do_reset(1'b0);
    run_stream(-1, cellQ.size());
    total++; if (syncCnt !== 0) begin bad++; $display("FAIL gate_nosync: got %0d want 0", syncCnt); end
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL gate_words: got %h want 0", bus.o3WORDS); end
    do_reset(1'b0);
    run_stream(400, cellQ.size());
    total++; if (syncCnt !== 0) begin bad++; $display("FAIL gate_mid_nosync: got %0d want 0", syncCnt); end
    total++; if (bus.o3WORDS !== 48'h000044894489) begin bad++; $display("FAIL gate_mid_words: got %h want 000044894489", bus.o3WORDS); end
  endtask

  task automatic test_reset_mid();
    int len;
    do_reset(1'b1);
    run_stream(0, 400);
    total++; if (bus.o3WORDS !== 48'hAAAAAAAA4489) begin bad++; $display("FAIL pre_rst_words: got %h want aaaaaaaa4489", bus.o3WORDS); end
    repeat (10) @(negedge iCLK);
    iRESET_N = 1'b0;
    #1;
    total++; if (bus.oRCLK !== 1'b0) begin bad++; $display("FAIL midrst_rclk: got %b want 0", bus.oRCLK); end
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL midrst_words: got %h want 0", bus.o3WORDS); end
    total++; if (bus.oSYNC !== 1'b0) begin bad++; $display("FAIL midrst_sync: got %b want 0", bus.oSYNC); end
    total++; if (bus.oLOCK !== 1'b0) begin bad++; $display("FAIL midrst_lock: got %b want 0", bus.oLOCK); end
    repeat (3) @(negedge iCLK);
    iRESET_N = 1'b1;
    syncCnt = 0;
    for (int k = 0; k < 3; k++) begin
      run_window(-1, -1, len);
      total++; if (len !== 32) begin bad++; $display("FAIL postrst_len%0d: got %0d want 32", k, len); end
    end
    total++; if (syncCnt !== 0) begin bad++; $display("FAIL postrst_nosync: got %0d want 0", syncCnt); end
    total++; if (bus.o3WORDS !== 48'h0) begin bad++; $display("FAIL postrst_words: got %h want 0", bus.o3WORDS); end
  endtask

  initial begin
    winIdx  = 0;
    syncCnt = 0;
    syncAt  = -1;
    syncWin = '0;
    build_stream();
    test_reset();
    test_alternate();
    test_correction();
    test_back_to_back();
    test_sync();
    test_start_gate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mfm_dpll_sync.md
# mfm_dpll_sync

Digital data separator and address-mark detector for the КР1818ВГ93/WD1793 HDL model. It recovers the bit-cell clock from raw drive read pulses with a simple digital PLL. It shifts the recovered MFM cell stream into a 48-bit window and flags the triple-A1 sync pattern. It sits directly upstream of the MFM byte decoder and drives that decoder's RCLK, 3-word window and SYNC inputs.

## Interface
- HALF_CELL, 32: iCLK cycles per MFM half-cell, i.e. per recovered RCLK phase. Even, ≥8. 32 gives DD 250 kbps at 16 MHz.
- SYNC_PAT, 48'h448944894489: window value that constitutes a sync mark (3× A1 with missing clock).
- iCLK  in  1  system clock; all logic on posedge.
- iRESET_N  in  1  asynchronous, active-low reset.
- iRDATA_N  in  1  raw read data from drive, active-low pulses, asynchronous to iCLK, ≥2 iCLK wide.
- iSTART  in  1  read-operation enable from main FSM; low clears window and sync logic.
- oRCLK  out  1  recovered cell clock; toggles once per half-cell window.
- o3WORDS  out  48  MFM cell shift register; bit 0 is the newest cell.
- oSYNC  out  1  one-cycle strobe: window equals SYNC_PAT.
- oLOCK  out  1  high while recent pulses arrive inside the centre band.

## Operation
- Input: 2-flop synchronizer on iRDATA_N. A falling edge on the synchronized signal produces a one-cycle pulse event P.
- Phase counter rPH counts 0..HALF_CELL-1. MID = HALF_CELL/2.
- Window close (WC) occurs when rPH == HALF_CELL-1 at a clock edge. Effect: rPH <= 0, oRCLK toggles, o3WORDS <= {o3WORDS[46:0], rHIT}, rHIT <= 0.
- rHIT is set by P and holds until the next WC.
- A P that coincides with WC goes into the next window: rHIT <= 1 after the shift.
- Phase correction, applied on P when no WC occurs in the same cycle, with c = rPH:
  - c < MID-1: rPH holds at c (retard one cycle).
  - MID < c < HALF_CELL-2: rPH <= c+2 (advance one cycle).
  - Otherwise: normal c+1.
  - At most one correction per window. Later P in the same window only set rHIT.
- Lock: 4-bit saturating counter rLK.
  - P with |c-MID| ≤ HALF_CELL/8: rLK increments.
  - P outside that band: rLK decrements.
  - oLOCK = (rLK ≥ 8).
- iSTART low, or falling: next edge clears o3WORDS, rHIT and oSYNC. The DPLL and the lock counter keep running, so oRCLK continues.
- Sync: registered compare. oSYNC = 1 for the cycle after the WC in which the shifted window becomes SYNC_PAT, only if iSTART is high.
  - A 4th consecutive A1 re-matches 16 windows later and strobes again. This is intended, and the decoder re-aligns on it.
- Reset (async, iRESET_N low): rPH = 0, oRCLK = 0, o3WORDS = 0, rHIT = 0, oSYNC = 0, rLK = 0, oLOCK = 0, synchronizer flops = 1 (idle).
  - Reset asserted mid-window abandons that window entirely.

## Timing
- Pulse-to-rHIT latency: 3 iCLK (2 sync + edge detect).
- With no pulses, oRCLK period is exactly 2·HALF_CELL iCLK. WC spacing is HALF_CELL cycles; correction makes it HALF_CELL±1.
- o3WORDS and oRCLK change on the same edge. The downstream stage detects the oRCLK change one cycle later, when o3WORDS is already stable.
- oSYNC is high exactly 1 cycle, 1 cycle after the matching WC, and never two cycles in a row.
- Back-to-back P in consecutive windows is legal. P in every window gives window bits all 1.
- Ignore the first 2 cycles after reset release (synchronizer settling). No P is generated from the reset value.

## Test plan
- Reset, no pulses, HALF_CELL=32 -> oRCLK toggles every 32 cycles from 0; o3WORDS stays 0; oLOCK 0.
- Pulses at rPH = 16 in every other window (iSTART=1) -> o3WORDS alternates ...0101; rPH sequence never corrected; oLOCK rises after 8 pulses.
- Pulse stream drifting +1 cycle/window -> each late pulse (c > 16) causes one advance; the pulse phase re-centres to within ±1 of 16; no bit lost.
- MFM stream of 12×4E gap, 12×00, then 3×A1 (4489 cells) with iSTART=1 -> exactly one oSYNC, 1 cycle after the 48th A1 cell WC; o3WORDS = 48'h448944894489 at that cycle.
- Same stream with iSTART=0 -> no oSYNC; o3WORDS = 0. Raise iSTART mid-stream -> window fills from 0.
- Assert iRESET_N low mid-window during a sync sequence -> all outputs 0 immediately (async); after release, no spurious oSYNC or P.
